hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32 core. Drives forwarda/forwardb for the EX-stage operand muxes.
//  Produces stall/flush for the F/D/E/M/W pipeline registers for load-use, taken branch, multi-cycle EX ops and data-memory wait.
//  Keeps a saturating stall-cycle perf counter.
// PARAMETERS
//  MC_MAX_CYCLES  64  max cycles a multi-cycle EX op may hold EX before abort (>=2)
//  CNT_W          32  width of stall_cycles perf counter
// PORTS
//  clk           in   1   core clock, rising edge
//  rst_n         in   1   async active-low reset
//  rs1d,rs2d     in   5   source regs in D
//  rs1e,rs2e     in   5   source regs in E
//  rde,rdm,rdw   in   5   dest regs in E/M/W
//  regwritem,w   in   1   reg write enable in M/W
//  loade         in   1   instruction in E is a load
//  pcsrce        in   1   branch/jump taken, resolved in E
//  mc_starte     in   1   multi-cycle op (div) present in E, level
//  mc_done       in   1   multi-cycle unit result valid, 1-cycle pulse
//  dmem_req      in   1   load/store in M
//  dmem_ready    in   1   data memory accepts/returns this cycle
//  forwarda,b    out  2   00=rf, 01=W result, 10=M aluresult (11 never driven)
//  stallf,stalld,stalle,stallm  out 1  hold stage register
//  flushd,flushe,flushm,flushw  out 1  bubble stage register
//  mc_error      out  1   sticky: multi-cycle op exceeded MC_MAX_CYCLES
//  stall_cycles  out CNT_W cycles with stallf=1, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RUN, mc_cnt=0, mc_error=0, stall_cycles=0; all stall/flush=0, forwarda/b=00.
//  Forwarding (comb, 0-cycle): fwdX=10 if regwritem&&rdm!=0&&rdm==rsXe; else 01 if regwritew&&rdw!=0&&rdw==rsXe; else 00. M beats W.
//  lwstall = loade && rde!=0 && (rde==rs1d || rde==rs2d).
//  FSM states RUN, MC_WAIT, MEM_WAIT; outputs comb from state+inputs, state registered.
//  Priority (high->low): MEM_WAIT/mem stall > MC_WAIT > pcsrce > lwstall.
//  Mem stall: dmem_req && !dmem_ready (any state). Effect: stallf,d,e,m=1, flushw=1, all other flushes 0. State -> MEM_WAIT.
//   Leave to prior state when dmem_ready=1; that cycle is not stalled. pcsrce held by frozen E, acts on release.
//  RUN: mc_starte=1 -> MC_WAIT next cycle, mc_cnt=1; that cycle: stallf,d,e=1, flushm=1.
//   pcsrce=1: flushd=flushe=1, stallf=stalld=0 (overrides lwstall).
//   lwstall (no pcsrce): stallf=stalld=1, flushe=1. Load issues ≥1 bubble; M->E path covers rest.
//  MC_WAIT: stallf,d,e=1, flushm=1 each cycle; mc_cnt++.
//   mc_done=1 -> that cycle releases stalls (E advances) -> RUN.
//   mc_cnt==MC_MAX_CYCLES without done -> mc_error<=1, flushe=1 (kill op), -> RUN.
//   mc_done and timeout same cycle: done wins, no error.
//   mc_starte is ignored in the release cycle (no retrigger for the same op).
//  stall_cycles += 1 when stallf=1, stops at 2^CNT_W-1; never wraps.
//  Reset mid-MC_WAIT/MEM_WAIT: immediate return to RUN, outputs 0 asynchronously.
//  mc_error clears only on reset.
// STRUCTURE
//  Package riscv_hazard_pkg: typedef enum logic[1:0] fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
//   Also hz_state_t {RUN, MC_WAIT, MEM_WAIT}. Shared with the EX forwarding mux.
//  Sub-module fwd_select (comb, one instance per operand: rs, rdm, rdw, regwritem/w -> fwd_sel_t).
//  Top: FSM + mc_cnt + perf counter in one always_ff; output decode in one always_comb.
// TESTING
//  1 rs1e=5,rdm=5,regwritem=1,rdw=5,regwritew=1 -> forwarda=10; rdm=0 same -> 01; rdw=x0 also -> 00.
//  2 loade=1,rde=7,rs2d=7 -> stallf=stalld=flushe=1 for 1 cycle; add pcsrce=1 -> flushd=flushe=1, stallf=0.
//  3 mc_starte=1, mc_done 10 cycles later -> stallf,d,e=1 and flushm=1 for 10 cycles; release on done cycle; stall_cycles+=10.
//  4 MC_MAX_CYCLES=8, no mc_done -> mc_error=1 after cycle 8, flushe=1, back to RUN; stays 1 until rst_n.
//  5 dmem_req=1,dmem_ready=0 for 3 cycles during MC_WAIT -> stallf,d,e,m=1, flushw=1; then MC_WAIT resumes.
//  6 rst_n=0 mid MC_WAIT -> all outputs 0 same cycle; stall_cycles=0. Preset near max -> saturates at all-ones.

Source files
------------

// File: rtl/riscv_hazard_pkg.sv
// Shared hazard-control types: EX operand forwarding select and hazard FSM state.
// Also used by the EX-stage forwarding mux.
package riscv_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MC_WAIT  = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic stallf;
    logic stalld;
    logic stalle;
    logic stallm;
    logic flushd;
    logic flushe;
    logic flushm;
    logic flushw;
  } hz_ctrl_t;

  // Load in E writing a register that the instruction in D reads; x0 never hazards.
  function automatic logic lw_hazard(input logic       loade,
                                     input logic [4:0] rde,
                                     input logic [4:0] rs1d,
                                     input logic [4:0] rs2d);
    return loade && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));
  endfunction

endpackage

// File: rtl/fwd_select.sv
// EX operand forwarding select for one source register.
// The newer M-stage result takes precedence over the W-stage result.
module fwd_select
  import riscv_hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwritem,
  input  logic       regwritew,
  output fwd_sel_t   fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (regwritem && (rdm != 5'd0) && (rdm == rs)) begin
      fwd = FWD_MEM;
    end else if (regwritew && (rdw != 5'd0) && (rdw == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: operand forwarding, stall/flush
// generation for load-use, taken branch, multi-cycle EX ops and data-memory wait.
module hazard_ctrl
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned MC_MAX_CYCLES = 64,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rs1e,
  input  logic [4:0]       rs2e,
  input  logic [4:0]       rde,
  input  logic [4:0]       rdm,
  input  logic [4:0]       rdw,
  input  logic             regwritem,
  input  logic             regwritew,
  input  logic             loade,
  input  logic             pcsrce,
  input  logic             mc_starte,
  input  logic             mc_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       forwarda,
  output logic [1:0]       forwardb,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             flushd,
  output logic             flushe,
  output logic             flushm,
  output logic             flushw,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned MC_W = $clog2(MC_MAX_CYCLES + 1);

  hz_state_t        state_q, state_d;
  hz_state_t        ret_q, ret_d;
  hz_state_t        eff_state;
  logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic             done_pend_q, done_pend_d;
  logic             mc_error_q;
  logic             set_error;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             mem_stall;
  logic             lwstall;
  logic             mc_done_eff;
  logic             mc_timeout;
  hz_ctrl_t         ctrl_raw;
  fwd_sel_t         fwd_a, fwd_b;

  fwd_select u_fwd_a (
    .rs        (rs1e),
    .rdm       (rdm),
    .rdw       (rdw),
    .regwritem (regwritem),
    .regwritew (regwritew),
    .fwd       (fwd_a)
  );

  fwd_select u_fwd_b (
    .rs        (rs2e),
    .rdm       (rdm),
    .rdw       (rdw),
    .regwritem (regwritem),
    .regwritew (regwritew),
    .fwd       (fwd_b)
  );

  assign mem_stall   = dmem_req && !dmem_ready;
  assign lwstall     = lw_hazard(loade, rde, rs1d, rs2d);
  // A memory stall freezes the pipeline; decode proceeds as in the interrupted state.
  assign eff_state   = (state_q == MEM_WAIT) ? ret_q : state_q;
  // A done pulse seen while frozen by memory is remembered so it is not lost.
  assign mc_done_eff = mc_done || done_pend_q;
  assign mc_timeout  = (mc_cnt_q == MC_W'(MC_MAX_CYCLES));

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    mc_cnt_d    = mc_cnt_q;
    done_pend_d = done_pend_q;
    set_error   = 1'b0;
    if (mem_stall) begin
      state_d = MEM_WAIT;
      ret_d   = eff_state;
      if ((eff_state == MC_WAIT) && mc_done) begin
        done_pend_d = 1'b1;
      end
    end else begin
      unique case (eff_state)
        RUN: begin
          state_d = RUN;
          if (mc_starte) begin
            state_d     = MC_WAIT;
            mc_cnt_d    = MC_W'(1);
            done_pend_d = 1'b0;
          end
        end
        MC_WAIT: begin
          if (mc_done_eff) begin
            state_d     = RUN;
            mc_cnt_d    = '0;
            done_pend_d = 1'b0;
          end else if (mc_timeout) begin
            state_d   = RUN;
            mc_cnt_d  = '0;
            set_error = 1'b1;
          end else begin
            state_d  = MC_WAIT;
            mc_cnt_d = mc_cnt_q + MC_W'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Output decode, before reset gating; also feeds the perf counter.
  always_comb begin
    ctrl_raw = '0;
    if (mem_stall) begin
      ctrl_raw.stallf = 1'b1;
      ctrl_raw.stalld = 1'b1;
      ctrl_raw.stalle = 1'b1;
      ctrl_raw.stallm = 1'b1;
      ctrl_raw.flushw = 1'b1;
    end else begin
      unique case (eff_state)
        RUN: begin
          if (mc_starte) begin
            ctrl_raw.stallf = 1'b1;
            ctrl_raw.stalld = 1'b1;
            ctrl_raw.stalle = 1'b1;
            ctrl_raw.flushm = 1'b1;
          end else if (pcsrce) begin
            ctrl_raw.flushd = 1'b1;
            ctrl_raw.flushe = 1'b1;
          end else if (lwstall) begin
            ctrl_raw.stallf = 1'b1;
            ctrl_raw.stalld = 1'b1;
            ctrl_raw.flushe = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done_eff) begin
            ctrl_raw = '0;
          end else if (mc_timeout) begin
            // Kill the op: hold F/D so the D instruction survives, bubble E and M.
            ctrl_raw.stallf = 1'b1;
            ctrl_raw.stalld = 1'b1;
            ctrl_raw.flushe = 1'b1;
            ctrl_raw.flushm = 1'b1;
          end else begin
            ctrl_raw.stallf = 1'b1;
            ctrl_raw.stalld = 1'b1;
            ctrl_raw.stalle = 1'b1;
            ctrl_raw.flushm = 1'b1;
          end
        end
        default: begin
          ctrl_raw = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      ret_q          <= RUN;
      mc_cnt_q       <= '0;
      done_pend_q    <= 1'b0;
      mc_error_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      mc_cnt_q    <= mc_cnt_d;
      done_pend_q <= done_pend_d;
      if (set_error) begin
        mc_error_q <= 1'b1;
      end
      if (ctrl_raw.stallf && (stall_cycles_q != {CNT_W{1'b1}})) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
    end
  end

  // All control outputs drop as soon as reset asserts, independent of the clock.
  assign {stallf, stalld, stalle, stallm, flushd, flushe, flushm, flushw} =
      rst_n ? ctrl_raw : '0;
  assign forwarda     = rst_n ? fwd_a : FWD_RF;
  assign forwardb     = rst_n ? fwd_b : FWD_RF;
  assign mc_error     = mc_error_q;
  assign stall_cycles = stall_cycles_q;

endmodule
